// File: rtl/exec_stage.sv
// exec_stage: three-state execute unit (IDLE -> EXEC -> WB) with a 4x8 register
// file and a {C,Z,S} flags register. All arithmetic is done by an external ALU.
`timescale 1ns/1ps

module exec_stage #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [3:0] issue_op,
    input  logic [1:0] issue_dst,
    input  logic [1:0] issue_src,
    input  logic       issue_use_imm,
    input  logic [7:0] issue_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_z,
    input  logic       alu_s,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_s,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  regs_r [0:3];
    logic [2:0]  flags_r;
    logic [3:0]  op_r;
    logic [1:0]  dst_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [7:0]  res_r;
    logic [2:0]  cap_flags_r;
    logic        ready_r;
    logic        done_r;

    logic [7:0]  operand_b_s;
    logic        writes_reg_s;
    logic        writes_flags_s;

    // Operand B source selection at handshake time
    always_comb begin
        operand_b_s = 8'h00;
        if (issue_use_imm) begin
            operand_b_s = issue_imm;
        end else begin
            operand_b_s = regs_r[issue_src];
        end
    end

    // Decode which architectural state the latched op is allowed to modify
    always_comb begin
        writes_reg_s   = 1'b0;
        writes_flags_s = 1'b0;
        case (op_r)
            4'd0, 4'd1: begin
                writes_reg_s   = 1'b1;
                writes_flags_s = 1'b0;
            end
            4'd2, 4'd3: begin
                writes_reg_s   = 1'b1;
                writes_flags_s = 1'b1;
            end
            default: begin
                writes_reg_s   = 1'b0;
                writes_flags_s = 1'b0;
            end
        endcase
    end

    // Sequencer, operand/capture registers and architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            op_r        <= 4'd0;
            dst_r       <= 2'd0;
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            res_r       <= 8'h00;
            cap_flags_r <= 3'b000;
            flags_r     <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= REG_INIT;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // ready_r is high throughout IDLE, so valid alone completes the handshake
                    if (issue_valid) begin
                        op_r    <= issue_op;
                        dst_r   <= issue_dst;
                        a_r     <= regs_r[issue_dst];
                        b_r     <= operand_b_s;
                        ready_r <= 1'b0;
                        state_r <= ST_EXEC;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                    done_r <= 1'b0;
                end
                ST_EXEC: begin
                    res_r       <= alu_result;
                    cap_flags_r <= {alu_c, alu_z, alu_s};
                    done_r      <= 1'b1;
                    ready_r     <= 1'b0;
                    state_r     <= ST_WB;
                end
                ST_WB: begin
                    if (writes_reg_s) begin
                        regs_r[dst_r] <= res_r;
                    end else begin
                        regs_r[dst_r] <= regs_r[dst_r];
                    end
                    if (writes_flags_s) begin
                        flags_r <= cap_flags_r;
                    end else begin
                        flags_r <= flags_r;
                    end
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign issue_ready = ready_r;
    assign done        = done_r;
    assign alu_a       = a_r;
    assign alu_b       = b_r;
    assign alu_op      = op_r;
    assign flag_c      = flags_r[2];
    assign flag_z      = flags_r[1];
    assign flag_s      = flags_r[0];
    assign rd_data     = regs_r[rd_sel];

endmodule

// File: tb/tb_exec_stage.sv
// Randomised scoreboard bench for exec_stage with a behavioural ALU and
// an architectural reference model (register array + flags).
`timescale 1ns/1ps

module tb_exec_stage;

    localparam logic [7:0] INIT = 8'h3C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [3:0] issue_op = 4'd0;
    logic [1:0] issue_dst = 2'd0;
    logic [1:0] issue_src = 2'd0;
    logic       issue_use_imm = 1'b0;
    logic [7:0] issue_imm = 8'h00;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_c, alu_z, alu_s;
    logic [1:0] rd_sel = 2'd0;
    logic [7:0] rd_data;
    logic       flag_c, flag_z, flag_s;
    logic       done;

    exec_stage #(.REG_INIT(INIT)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dst(issue_dst), .issue_src(issue_src),
        .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
        .done(done)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU; non-flag ops report c=1 so stray flag updates become visible
    always_comb begin
        logic [8:0] sum;
        sum        = 9'd0;
        alu_result = 8'h00;
        alu_c      = 1'b0;
        case (alu_op)
            4'd0: begin alu_result = alu_b;  alu_c = 1'b1; end
            4'd1: begin alu_result = ~alu_a; alu_c = 1'b1; end
            4'd2: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = sum[7:0]; alu_c = sum[8]; end
            4'd3: begin alu_result = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            default: begin alu_result = alu_a ^ alu_b ^ 8'h5A; alu_c = 1'b1; end
        endcase
        alu_z = (alu_result == 8'h00);
        alu_s = alu_result[7];
    end

    typedef struct {
        int op;
        int a;
        int b;
        int regs[4];
        int flags;
        int hs;
    } exp_t;

    exp_t q[$];
    int   mreg[4];
    int   mflags;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_hs = 0;
    bit   mon_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Higher-level model: what each instruction does to the architectural state
    task automatic model_exec(input int op, input int dst, input int src,
                              input bit use_imm, input int imm, output exp_t e);
        int ra, rb, res;
        ra  = mreg[dst];
        rb  = use_imm ? imm : mreg[src];
        res = 0;
        case (op)
            0: res = rb;
            1: res = 255 - ra;
            2: begin res = (ra + rb) % 256; mflags = ((ra + rb > 255) ? 4 : 0) + (res == 0 ? 2 : 0) + (res >= 128 ? 1 : 0); end
            3: begin res = (ra - rb + 256) % 256; mflags = ((ra < rb) ? 4 : 0) + (res == 0 ? 2 : 0) + (res >= 128 ? 1 : 0); end
            default: res = 0;
        endcase
        if (op < 4) mreg[dst] = res;
        e.op = op; e.a = ra; e.b = rb; e.flags = mflags; e.hs = cyc;
        for (int i = 0; i < 4; i++) e.regs[i] = mreg[i];
    endtask

    // Called at a negedge; returns at a negedge after the handshake edge
    task automatic issue(input int op, input int dst, input int src, input bit use_imm,
                         input int imm, input bit keep_valid, input bit push);
        int   n;
        exp_t e;
        n = 0;
        issue_valid = 1'b1;
        issue_op = op[3:0]; issue_dst = dst[1:0]; issue_src = src[1:0];
        issue_use_imm = use_imm; issue_imm = imm[7:0];
        while (!issue_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("issue_timeout", 0, 1);
            issue_valid = 1'b0;
            return;
        end
        last_hs = cyc;
        if (push) begin
            model_exec(op, dst, src, use_imm, imm, e);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (keep_valid) begin
            issue_op = 4'($urandom); issue_dst = 2'($urandom); issue_src = 2'($urandom);
            issue_use_imm = 1'($urandom); issue_imm = 8'($urandom);
        end else begin
            issue_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        chk("rst_issue_ready", int'(issue_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_flags", int'({flag_c, flag_z, flag_s}), 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            chk($sformatf("rst_R%0d", i), int'(rd_data), int'(INIT));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = int'(INIT);
        mflags = 0;
    endtask

    task automatic abort_add();
        issue(2, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, $urandom_range(0, 255), 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        model_reset();
        check_reset_state();
        @(negedge clk);
    endtask

    // Monitor: each done pulse retires the oldest expected instruction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    mon_busy = 1'b1;
                    e = q.pop_front();
                    chk("wb_alu_op", int'(alu_op), e.op);
                    chk("wb_alu_a", int'(alu_a), e.a);
                    chk("wb_alu_b", int'(alu_b), e.b);
                    chk("done_latency", cyc - e.hs, 2);
                    @(posedge clk);
                    #1;
                    chk("done_width", int'(done), 0);
                    chk("flags", int'({flag_c, flag_z, flag_s}), e.flags);
                    for (int i = 0; i < 4; i++) begin
                        rd_sel = 2'(i);
                        #1;
                        chk($sformatf("R%0d", i), int'(rd_data), e.regs[i]);
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        int prev_hs, gap, next_gap, n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(negedge clk);

        // Directed scenarios
        issue(0, 1, 0, 1'b1, 8'h7F, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        issue(0, 1, 0, 1'b1, 8'hFF, 1'b0, 1'b1);
        issue(2, 1, 0, 1'b1, 8'h01, 1'b0, 1'b1);
        issue(0, 2, 0, 1'b1, 8'h05, 1'b0, 1'b1);
        issue(0, 3, 0, 1'b1, 8'h07, 1'b0, 1'b1);
        issue(3, 2, 3, 1'b0, 8'h00, 1'b0, 1'b1);
        issue(1, 2, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        issue(4'hA, 2, 1, 1'b0, 8'h33, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        abort_add();

        // Continuous valid: one acceptance every three cycles
        issue(2, 0, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        prev_hs = last_hs;
        for (int k = 0; k < 5; k++) begin
            issue(k % 4, (k + 1) % 4, k % 4, k[0], 8'h90 + k, k < 4, 1'b1);
            chk("b2b_interval", last_hs - prev_hs, 3);
            prev_hs = last_hs;
        end

        // Randomised traffic with occasional aborts
        next_gap = $urandom_range(0, 3);
        for (int k = 0; k < 300; k++) begin
            int op;
            gap = next_gap;
            next_gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                issue_valid = 1'b0;
                n = 0;
                while ((q.size() != 0 || mon_busy || !issue_ready) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                abort_add();
            end else begin
                op = $urandom_range(0, 5);
                if (op >= 4) op = $urandom_range(4, 15);
                issue(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                      $urandom_range(0, 255), next_gap == 0, 1'b1);
            end
        end
        issue_valid = 1'b0;

        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
